// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared types and constants for the interval sequencer.
//   state_e       : sequencer FSM state (IDLE / RUN / HOLD)
//   MODE_ONESHOT  : expire once, then return to IDLE
//   MODE_PERIODIC : auto-reload the interval after every expire
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_down_counter.sv
// interval_down_counter: WIDTH-bit loadable down counter (datapath only).
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   load  : load q <= d (wins over en)
//   en    : decrement q by one
//   d     : load value
//   q     : current count
//   zero  : q == 0
module interval_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
    else if (en)   q <= q - WIDTH'(1);
  end

  assign zero = (q == '0);

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: programmable interval controller driving a down counter.
//   clk      : rising-edge clock
//   reset    : synchronous active-high clear of all state
//   start    : begin an interval (honoured only in IDLE)
//   stop     : abort from RUN/HOLD, no expire
//   pause    : freeze count while high in RUN
//   mode     : 0 one-shot, 1 periodic (captured at start)
//   load_val : interval value (captured at start)
//   count    : registered counter value
//   busy     : RUN or HOLD
//   paused   : HOLD
//   expire   : one-cycle pulse in the cycle count shows 0
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             expire
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   reload_q;
  logic               mode_q;
  logic               expire_q, expire_d;
  logic               busy_q, paused_q;
  logic               capture;

  logic               dp_load, dp_en;
  logic [WIDTH-1:0]   dp_d;
  logic [WIDTH-1:0]   cnt_q;
  logic               cnt_zero;
  logic               cnt_one;

  interval_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (dp_load),
    .en    (dp_en),
    .d     (dp_d),
    .q     (cnt_q),
    .zero  (cnt_zero)
  );

  assign cnt_one = (cnt_q == WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    dp_load  = 1'b0;
    dp_en    = 1'b0;
    dp_d     = '0;
    expire_d = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dp_load = 1'b1;
          if (load_val != '0) begin
            capture = 1'b1;
            dp_d    = load_val;
            state_d = RUN;
          end else begin
            // zero interval: expire immediately, never enter RUN
            expire_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          dp_load = 1'b1;
          state_d = IDLE;
        end else if (pause) begin
          state_d = HOLD;
        end else if (cnt_zero) begin
          // only reachable in periodic mode: reload after the expire cycle
          dp_load = 1'b1;
          dp_d    = reload_q;
        end else begin
          dp_en = 1'b1;
          if (cnt_one) begin
            expire_d = 1'b1;
            if (mode_q == MODE_ONESHOT) state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          dp_load = 1'b1;
          state_d = IDLE;
        end else if (!pause) begin
          // resume edge only changes state; counting picks up next cycle
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      expire_q <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (capture) begin
        reload_q <= load_val;
        mode_q   <= mode;
      end
      expire_q <= expire_d;
      // flags registered from next state so they align with count
      busy_q   <= (state_d != IDLE);
      paused_q <= (state_d == HOLD);
    end
  end

  assign count  = cnt_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign expire = expire_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start, stop, pause, mode;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy, paused, expire;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .load_val(load_val), .count(count), .busy(busy),
    .paused(paused), .expire(expire)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: an "active interval" with remaining count
  int m_cnt, m_rel;
  bit m_busy, m_paused, m_exp, m_per;

  task automatic model_step();
    if (reset) begin
      m_cnt = 0; m_rel = 0; m_busy = 0; m_paused = 0; m_exp = 0; m_per = 0;
    end else if (!m_busy) begin
      m_exp = start && (load_val == 0);
      if (start && load_val != 0) begin
        m_busy = 1; m_cnt = load_val; m_rel = load_val; m_per = mode;
      end
    end else if (stop) begin
      m_busy = 0; m_paused = 0; m_cnt = 0; m_exp = 0;
    end else if (pause) begin
      m_paused = 1; m_exp = 0;
    end else if (m_paused) begin
      m_paused = 0; m_exp = 0;
    end else if (m_cnt == 0) begin
      m_cnt = m_rel; m_exp = 0;
    end else begin
      m_cnt = m_cnt - 1;
      m_exp = (m_cnt == 0);
      if (m_cnt == 0 && !m_per) m_busy = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one edge, then compare all outputs against the model
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("count",  32'(count),  32'(m_cnt));
    chk("busy",   32'(busy),   32'(m_busy));
    chk("paused", 32'(paused), 32'(m_paused));
    chk("expire", 32'(expire), 32'(m_exp));
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; pause = 0; mode = 0; load_val = '0;
  endtask

  initial begin
    int n;
    reset = 1; idle_inputs();
    @(negedge clk);
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_busy",  32'(busy),  0);
    reset = 0;
    tick();

    // one-shot, load 3
    start = 1; mode = 0; load_val = 3;
    tick();
    idle_inputs();
    chk("os3_first", 32'(count), 3);
    for (int i = 2; i >= 0; i--) begin
      tick();
      chk("os3_cnt", 32'(count), 32'(i));
      chk("os3_exp", 32'(expire), 32'(i == 0));
    end
    chk("os3_busy_fall", 32'(busy), 0);
    tick();
    chk("os3_hold0", 32'(count), 0);

    // periodic, load 2, nine cycles
    start = 1; mode = 1; load_val = 2;
    for (int k = 0; k < 9; k++) begin
      tick();
      idle_inputs();
      chk("per2_cnt", 32'(count),  32'(2 - (k % 3)));
      chk("per2_exp", 32'(expire), 32'((k % 3) == 2));
      chk("per2_busy", 32'(busy), 1);
    end
    stop = 1; tick(); stop = 0;

    // one-shot 5, pause three cycles at count 3
    start = 1; mode = 0; load_val = 5;
    tick(); idle_inputs();
    tick(); tick();
    chk("pz_at3", 32'(count), 3);
    pause = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pz_cnt", 32'(count), 3);
      chk("pz_flag", 32'(paused), 1);
    end
    pause = 0;
    for (int k = 0; k < 5; k++) tick();

    // periodic 4, stop at count 1 with a simultaneous start
    start = 1; mode = 1; load_val = 4;
    tick(); idle_inputs();
    tick(); tick(); tick();
    chk("stop_at1", 32'(count), 1);
    stop = 1; start = 1; load_val = 7;
    tick();
    idle_inputs();
    chk("stop_cnt", 32'(count), 0);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_exp", 32'(expire), 0);
    tick();
    chk("stop_idle", 32'(busy), 0);

    // zero interval
    start = 1; mode = 1; load_val = 0;
    tick(); idle_inputs();
    chk("zero_exp", 32'(expire), 1);
    chk("zero_busy", 32'(busy), 0);
    tick();
    chk("zero_exp_off", 32'(expire), 0);

    // full-scale one-shot: expire 16 cycles after start
    start = 1; mode = 0; load_val = 15;
    n = 0;
    do begin
      tick(); idle_inputs(); n++;
    end while (!expire && n < 40);
    chk("max_period", 32'(n), 16);

    // periodic pause on the expire cycle
    start = 1; mode = 1; load_val = 2;
    tick(); idle_inputs(); tick(); tick();
    chk("pexp_exp", 32'(expire), 1);
    pause = 1; tick();
    chk("pexp_hold0", 32'(count), 0);
    chk("pexp_norep", 32'(expire), 0);
    pause = 0; tick(); tick();
    chk("pexp_reload", 32'(count), 2);
    stop = 1; tick(); stop = 0;

    // reset mid-count at 7
    start = 1; mode = 0; load_val = 10;
    tick(); idle_inputs(); tick(); tick(); tick();
    chk("mid_at7", 32'(count), 7);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_cnt", 32'(count), 0);
    chk("mid_rst_busy", 32'(busy), 0);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      reset    = ($urandom % 60) == 0;
      start    = ($urandom % 3) == 0;
      stop     = ($urandom % 14) == 0;
      pause    = ($urandom % 6) == 0;
      mode     = $urandom % 2;
      load_val = W'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
